// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry front-end for the board ALU: button synchronizer, debouncer,
// press-pulse generator and the load FSM that registers A, B, opcode and the result.
module alu_operand_sequencer #(
  parameter int N          = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic [3:0]   op_sw,
  input  logic         btn,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [N-1:0] alu_y,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         result_valid,
  output logic [1:0]   state
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } fsm_e;

  localparam logic [1:0] LED_LOAD_A  = 2'b00;
  localparam logic [1:0] LED_LOAD_B  = 2'b01;
  localparam logic [1:0] LED_LOAD_OP = 2'b10;
  localparam logic [1:0] LED_SHOW    = 2'b11;

  // ---------------------------------------------------------------------------
  // Button synchronizer and debouncer
  // ---------------------------------------------------------------------------
  logic          sync1_q, sync2_q;
  logic          btn_s;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  assign btn_s = sync2_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (btn_s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d   = btn_s;
      cnt_d   = '0;
      press_d = btn_s;  // only a rising level change is a press
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the two synchronizer stages.
      sync1_q <= btn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Load FSM with registered ALU operands, result and LED state code
  // ---------------------------------------------------------------------------
  fsm_e         state_q;
  logic [1:0]   state_led_q;
  logic [N-1:0] alu_a_q, alu_b_q, result_q;
  logic [3:0]   alu_ctrl_q;
  logic         zero_q, valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      state_led_q <= LED_LOAD_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_LOAD_A: begin
          if (press_q) begin
            alu_a_q     <= sw;
            state_q     <= S_LOAD_B;
            state_led_q <= LED_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (press_q) begin
            alu_b_q     <= sw;
            state_q     <= S_LOAD_OP;
            state_led_q <= LED_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          if (press_q) begin
            alu_ctrl_q <= op_sw;
            state_q    <= S_EXEC;  // LEDs keep showing LOAD_OP during EXEC
          end
        end
        S_EXEC: begin
          // The ALU has had one full cycle with the new opcode; capture it now.
          result_q    <= alu_y;
          zero_q      <= (alu_y == '0);
          valid_q     <= 1'b1;
          state_q     <= S_SHOW;
          state_led_q <= LED_SHOW;
        end
        S_SHOW: begin
          if (press_q) begin
            valid_q     <= 1'b0;
            state_q     <= S_LOAD_A;
            state_led_q <= LED_LOAD_A;
          end
        end
        default: begin
          state_q     <= S_LOAD_A;
          state_led_q <= LED_LOAD_A;
        end
      endcase
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_ctrl     = alu_ctrl_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign result_valid = valid_q;
  assign state        = state_led_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer: press latency, operand entry table,
// bounce rejection, SHOW return and asynchronous reset mid-sequence.
module tb_alu_operand_sequencer;

  localparam int N   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] sw;
  logic [3:0]   op_sw;
  logic         btn;
  logic [N-1:0] alu_a, alu_b, alu_y, result;
  logic [3:0]   alu_ctrl;
  logic         zero, result_valid;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] op;
    logic [3:0] exp_result;
    logic       exp_zero;
  } vec_t;

  vec_t vecs [5];

  alu_operand_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .op_sw        (op_sw),
    .btn          (btn),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_y        (alu_y),
    .result       (result),
    .zero         (zero),
    .result_valid (result_valid),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Board ALU stand-in: 0000 AND, 0001 OR, 0100 ADD, 0101 SUB, others XOR.
  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0100: alu_y = alu_a + alu_b;
      4'b0101: alu_y = alu_a - alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; holds the button long enough to debounce both edges.
  task automatic press();
    btn = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    btn = 1'b0;
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctrl"}, alu_ctrl, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_valid"}, result_valid, 0);
    check({tag, "_state"}, state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;

    vecs[0] = '{a: 4'h5, b: 4'h5, op: 4'b0101, exp_result: 4'h0, exp_zero: 1'b1};
    vecs[1] = '{a: 4'hF, b: 4'h1, op: 4'b0100, exp_result: 4'h0, exp_zero: 1'b1};
    vecs[2] = '{a: 4'hC, b: 4'hA, op: 4'b0000, exp_result: 4'h8, exp_zero: 1'b0};
    vecs[3] = '{a: 4'hC, b: 4'h3, op: 4'b0001, exp_result: 4'hF, exp_zero: 1'b0};
    vecs[4] = '{a: 4'h9, b: 4'h4, op: 4'b0110, exp_result: 4'hD, exp_zero: 1'b0};

    rst_n = 1'b0;
    btn   = 1'b0;
    sw    = '0;
    op_sw = '0;
    repeat (3) @(negedge clk);
    check_all_clear("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_clear("after_reset");

    // Press latency: button high before edge 1, pulse only in the cycle after edge 6.
    sw  = 4'h5;
    btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("pulse_edge%0d", k), dut.press_q, (k == 6));
    end
    check("latency_alu_a", alu_a, 4'h5);
    check("latency_state", state, 2'b01);
    btn = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    sw = 4'h3;
    press();
    check("seq0_alu_b", alu_b, 4'h3);
    check("seq0_state_b", state, 2'b10);

    // Opcode press with cycle-by-cycle look at the EXEC cycle.
    op_sw = 4'b0100;
    btn   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check("exec_pre_ctrl", alu_ctrl, 4'h0);
        check("exec_pre_state", state, 2'b10);
      end
      if (k == 7) begin
        check("exec_ctrl", alu_ctrl, 4'h4);
        check("exec_state", state, 2'b10);
        check("exec_valid", result_valid, 0);
        check("exec_result_old", result, 4'h0);
      end
      if (k == 8) begin
        check("show_result", result, 4'h8);
        check("show_zero", zero, 0);
        check("show_valid", result_valid, 1);
        check("show_state", state, 2'b11);
      end
    end
    btn = 1'b0;
    repeat (DEB + 4) @(negedge clk);

    press();
    check("ret0_valid", result_valid, 0);
    check("ret0_state", state, 2'b00);
    check("ret0_result_held", result, 4'h8);

    foreach (vecs[i]) begin
      sw = vecs[i].a;
      press();
      check($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d_state_a", i), state, 2'b01);
      sw = vecs[i].b;
      press();
      check($sformatf("v%0d_alu_b", i), alu_b, vecs[i].b);
      check($sformatf("v%0d_state_b", i), state, 2'b10);
      op_sw = vecs[i].op;
      press();
      check($sformatf("v%0d_ctrl", i), alu_ctrl, vecs[i].op);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("v%0d_zero", i), zero, vecs[i].exp_zero);
      check($sformatf("v%0d_valid", i), result_valid, 1);
      check($sformatf("v%0d_state_show", i), state, 2'b11);
      press();
      check($sformatf("v%0d_ret_valid", i), result_valid, 0);
      check($sformatf("v%0d_ret_state", i), state, 2'b00);
      check($sformatf("v%0d_ret_result", i), result, vecs[i].exp_result);
    end

    // Bounce rejection in LOAD_B: highs of 1..3 cycles separated by 2 low cycles.
    sw = 4'h2;
    press();
    sw     = 4'hE;
    pulses = 0;
    for (int len = 1; len <= 3; len++) begin
      btn = 1'b1;
      repeat (len) begin
        @(negedge clk);
        pulses += int'(dut.press_q);
      end
      btn = 1'b0;
      repeat (2) begin
        @(negedge clk);
        pulses += int'(dut.press_q);
      end
    end
    repeat (10) begin
      @(negedge clk);
      pulses += int'(dut.press_q);
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_state", state, 2'b01);
    check("bounce_alu_b", alu_b, 4'h4);
    check("bounce_alu_a", alu_a, 4'h2);

    // Asynchronous reset between edges while in LOAD_OP.
    sw = 4'h7;
    press();
    check("pre_rst_state", state, 2'b10);
    check("pre_rst_alu_b", alu_b, 4'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_clear("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sw    = 4'h9;
    press();
    check("post_rst_alu_a", alu_a, 4'h9);
    check("post_rst_alu_b", alu_b, 4'h0);
    check("post_rst_state", state, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Sequential front-end that feeds the board-level combinational ALU from slide switches and one push-button. The user enters operand A, then operand B, then the 4-bit operation code, one button press per item. The block drives the registered values into the ALU, captures the ALU result one cycle later, and holds it together with a zero flag for the display/LED stage. It contains the button synchronizer, the debouncer and the load state machine.

Parameters:
N, 4, operand and result width; matches the ALU width.
DEB_CYCLES, 250000, number of consecutive clock cycles the synchronized button must differ from its debounced level before the change is accepted; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
sw  input  N  operand switches; sampled on an accepted press in LOAD_A or LOAD_B.
op_sw  input  4  operation-code switches; sampled on an accepted press in LOAD_OP.
btn  input  1  raw, asynchronous, bouncing push-button; active-high.
alu_a  output  N  registered operand A to the ALU.
alu_b  output  N  registered operand B to the ALU.
alu_ctrl  output  4  registered operation code to the ALU.
alu_y  input  N  combinational ALU result.
result  output  N  captured ALU result.
zero  output  1  high when the captured result is 0.
result_valid  output  1  high while result holds a completed operation.
state  output  2  current FSM state for the LEDs: 00 LOAD_A, 01 LOAD_B, 10 LOAD_OP, 11 SHOW.

Behaviour:
- Reset (rst_n low, asynchronous): state=LOAD_A; alu_a, alu_b, alu_ctrl, result = 0; zero=0; result_valid=0. Synchronizer flops, debounced level, debounce counter and press pulse are all cleared. Reset asserted mid-sequence discards everything already loaded.
- Synchronizer: two flops on btn. Their output is btn_s.
- Debouncer:
  - When btn_s equals the debounced level, cnt=0.
  - Otherwise cnt increments each cycle.
  - On the edge where cnt==DEB_CYCLES-1 and btn_s still differs, the debounced level takes btn_s and cnt returns to 0.
  - A glitch shorter than DEB_CYCLES cycles resets cnt and is ignored.
- Press pulse: a one-cycle registered pulse, set on the same edge at which the debounced level goes 0 to 1. Falling-level changes produce no pulse.
- Press latency: if btn is held high from the first sampling edge (edge 1), the pulse is high during the cycle after edge DEB_CYCLES+2. Holding the button produces exactly one pulse. Releasing and pressing again is required for the next pulse.
- FSM, advancing on the edge where the pulse is high:
  - LOAD_A: alu_a<=sw, then go to LOAD_B.
  - LOAD_B: alu_b<=sw, then go to LOAD_OP.
  - LOAD_OP: alu_ctrl<=op_sw, then go to an internal EXEC state (state output reads 10 during EXEC).
  - EXEC: lasts exactly one cycle regardless of btn. result<=alu_y, zero<=(alu_y==0), result_valid<=1, then go to SHOW.
  - SHOW: the pulse sets result_valid<=0, then go to LOAD_A. result, zero, alu_a, alu_b and alu_ctrl keep their values until overwritten.
- While result_valid=0 the ALU outputs keep changing, but result updates only in EXEC.
- Arithmetic: no width change. result is exactly alu_y (N bits, wrap-around is the ALU's concern). Carry and overflow are not tracked.
- A pulse arriving while in EXEC is impossible: pulses are at least DEB_CYCLES+1 cycles apart.

Test Plan:
- N=4, DEB_CYCLES=4, reset then release: all outputs 0, state=00. Hold btn high: pulse first high after edge 6, only once.
- sw=5 press, sw=3 press, op_sw=0100 press: alu_a=5, alu_b=3, alu_ctrl=4. One cycle later result=8, zero=0, result_valid=1, state=11.
- Repeat with A=5, B=5, op=0101: result=0, zero=1. Repeat with A=F, B=1, op=0100: result=0, zero=1.
- In LOAD_B, apply btn bounce pulses of 1-3 cycles separated by 2 low cycles: no pulse, state stays 01, alu_b unchanged.
- In SHOW, press: result_valid=0, state=00, result still holds the previous value.
- Assert rst_n low asynchronously between clock edges while in LOAD_OP: outputs clear immediately, and after release the next press loads alu_a.
